// File: rtl/rvfpm_pkg.sv
// Shared encodings and the pipeline entry type for the RV32F FMV.W.X move path.
// Decode lives here so every consumer agrees on the exact match pattern.
package rvfpm_pkg;

    localparam logic [6:0] OP_FP          = 7'b1010011;
    localparam logic [6:0] FUNCT7_FMV_W_X = 7'b1111000;
    localparam logic [2:0] FUNCT3_FMV     = 3'b000;
    localparam logic [4:0] RS2_FMV        = 5'b00000;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic [31:0] data;
    } fmv_stage_t;

    // Only the exact FMV.W.X pattern matches; FMV.X.W and arithmetic ops share OP_FP.
    function automatic logic is_fmv_w_x(input logic [31:0] insn);
        return (insn[6:0]   == OP_FP)
            && (insn[31:25] == FUNCT7_FMV_W_X)
            && (insn[14:12] == FUNCT3_FMV)
            && (insn[24:20] == RS2_FMV);
    endfunction

    function automatic logic idx_in_range(input logic [4:0] idx, input int unsigned n);
        return 32'(idx) < n;
    endfunction

endpackage

// File: rtl/rvfpm_regfile.sv
// FP register file: one synchronous write port, one asynchronous read port,
// and an asynchronous active-low clear of every entry.
module rvfpm_regfile
    import rvfpm_pkg::*;
#(
    parameter int NUM_REGS = 32
) (
    input  logic        ck,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr,
    output logic [31:0] rdata
);

    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [31:0] mem [NUM_REGS];

    // NOTE: this array is cleared on reset because a reset register file must
    // read as zero; storage that need not be observable after reset would skip it.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && idx_in_range(waddr, NUM_REGS)) begin
            // NOTE: state is written with <= so every flop samples pre-edge values.
            mem[waddr[AW-1:0]] <= wdata;
        end
    end

    always_comb begin
        rdata = '0;
        if (idx_in_range(raddr, NUM_REGS)) begin
            rdata = mem[raddr[AW-1:0]];
        end
    end

endmodule

// File: rtl/fmv_w_x_pipe.sv
// FMV.W.X move pipeline: decodes the move, carries it PIPELINE_STAGES-1 stages,
// then commits the integer bits unchanged into the FP register file.
module fmv_w_x_pipe
    import rvfpm_pkg::*;
#(
    parameter int NUM_REGS        = 32,
    parameter int PIPELINE_STAGES = 4
) (
    input  logic        ck,
    input  logic        rst,
    input  logic        enable,
    input  logic [31:0] instruction,
    input  logic [31:0] data_fromXReg,
    input  logic [4:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        hazard,
    output logic        busy
);

    fmv_stage_t dec_entry;
    fmv_stage_t commit_entry;
    logic       commit_we;
    logic       stage_busy;
    logic       stage_hazard;
    logic       unused_rs1;

    // rs1 is already resolved into data_fromXReg, so its index field is not needed.
    assign unused_rs1 = ^instruction[19:15];

    always_comb begin
        dec_entry.valid = is_fmv_w_x(instruction);
        dec_entry.rd    = instruction[11:7];
        dec_entry.data  = data_fromXReg;
    end

    // Out-of-range destinations travel the pipe but never raise a write.
    assign commit_we = enable && commit_entry.valid
                    && idx_in_range(commit_entry.rd, NUM_REGS);

    generate
        if (PIPELINE_STAGES == 1) begin : g_direct
            assign commit_entry = dec_entry;
            assign stage_busy   = 1'b0;
            assign stage_hazard = 1'b0;
        end else begin : g_stages
            localparam int NS = PIPELINE_STAGES - 1;

            fmv_stage_t stage_q [NS];

            always_ff @(posedge ck or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < NS; i++) begin
                        stage_q[i] <= '0;
                    end
                end else if (enable) begin
                    stage_q[0] <= dec_entry;
                    for (int i = 1; i < NS; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign commit_entry = stage_q[NS-1];

            // The last stage stops counting as a hazard in the cycle it writes,
            // since the register file already forwards nothing and the next read sees it.
            always_comb begin
                // NOTE: defaults first keep these combinational and latch-free.
                stage_busy   = 1'b0;
                stage_hazard = 1'b0;
                for (int i = 0; i < NS; i++) begin
                    if (stage_q[i].valid) begin
                        stage_busy = 1'b1;
                        if (stage_q[i].rd == rd_addr && !(i == NS - 1 && commit_we)) begin
                            stage_hazard = 1'b1;
                        end
                    end
                end
            end
        end
    endgenerate

    // With a single stage the commit entry is pure decode, so gate with reset
    // to keep the write port quiet while rst is low.
    assign rf_we    = rst && commit_we;
    assign rf_waddr = rst ? commit_entry.rd   : 5'd0;
    assign rf_wdata = rst ? commit_entry.data : 32'd0;
    assign busy     = rst && stage_busy;
    assign hazard   = rst && stage_hazard;

    rvfpm_regfile #(
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .ck    (ck),
        .rst   (rst),
        .we    (rf_we),
        .waddr (rf_waddr),
        .wdata (rf_wdata),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_fmv_w_x_pipe.sv
// Directed bench for fmv_w_x_pipe: a 4-stage/32-register instance and a
// 1-stage/8-register instance share clock, reset and instruction stream.
module tb_fmv_w_x_pipe;

    logic        ck = 1'b0;
    logic        rst;
    logic        enable;
    logic [31:0] instruction;
    logic [31:0] data_fromXReg;
    logic [4:0]  rd_addr4, rd_addr1;

    logic [31:0] rd_data4, rf_wdata4, rd_data1, rf_wdata1;
    logic [4:0]  rf_waddr4, rf_waddr1;
    logic        rf_we4, hazard4, busy4, rf_we1, hazard1, busy1;

    int checks = 0;
    int errors = 0;

    always #5 ck = ~ck;

    fmv_w_x_pipe #(.NUM_REGS(32), .PIPELINE_STAGES(4)) u4 (
        .ck(ck), .rst(rst), .enable(enable), .instruction(instruction),
        .data_fromXReg(data_fromXReg), .rd_addr(rd_addr4), .rd_data(rd_data4),
        .rf_we(rf_we4), .rf_waddr(rf_waddr4), .rf_wdata(rf_wdata4),
        .hazard(hazard4), .busy(busy4)
    );

    fmv_w_x_pipe #(.NUM_REGS(8), .PIPELINE_STAGES(1)) u1 (
        .ck(ck), .rst(rst), .enable(enable), .instruction(instruction),
        .data_fromXReg(data_fromXReg), .rd_addr(rd_addr1), .rd_data(rd_data1),
        .rf_we(rf_we1), .rf_waddr(rf_waddr1), .rf_wdata(rf_wdata1),
        .hazard(hazard1), .busy(busy1)
    );

    function automatic logic [31:0] fmv(input logic [4:0] rd);
        return {7'b1111000, 5'd0, 5'd1, 3'b000, rd, 7'b1010011};
    endfunction

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; enable = 1'b1; rd_addr4 = 5'd4; rd_addr1 = 5'd4;
        instruction = fmv(5'd4); data_fromXReg = 32'hCAFEF00D;
        #2;
        checks++; if (rf_we1 !== 1'b0) begin errors++; $display("FAIL reset_we1 got %b exp 0", rf_we1); end
        checks++; if (rf_wdata1 !== 32'd0) begin errors++; $display("FAIL reset_wdata1 got %h exp 0", rf_wdata1); end
        checks++; if (rf_waddr1 !== 5'd0) begin errors++; $display("FAIL reset_waddr1 got %0d exp 0", rf_waddr1); end
        checks++; if (busy4 !== 1'b0 || hazard4 !== 1'b0 || rf_we4 !== 1'b0) begin errors++; $display("FAIL reset_flags4 got %b%b%b exp 000", busy4, hazard4, rf_we4); end
        tick(); tick();
        checks++; if (busy4 !== 1'b0 || rd_data4 !== 32'd0 || rd_data1 !== 32'd0) begin errors++; $display("FAIL reset_hold got busy %b rd4 %h rd1 %h exp 0", busy4, rd_data4, rd_data1); end
        instruction = 32'd0; rst = 1'b1;
    endtask

    task automatic test_single();
        rd_addr4 = 5'd5; enable = 1'b1;
        instruction = fmv(5'd5); data_fromXReg = 32'h3F800000;
        tick();  // E0
        instruction = 32'd0; #1;
        checks++; if (busy4 !== 1'b1 || hazard4 !== 1'b1 || rf_we4 !== 1'b0) begin errors++; $display("FAIL single_e0 got busy %b hz %b we %b exp 1 1 0", busy4, hazard4, rf_we4); end
        tick();  // E1
        checks++; if (rf_we4 !== 1'b0) begin errors++; $display("FAIL single_e1_we got %b exp 0", rf_we4); end
        tick();  // E2: commit window of E3
        checks++; if (rf_we4 !== 1'b1 || rf_waddr4 !== 5'd5 || rf_wdata4 !== 32'h3F800000) begin errors++; $display("FAIL single_commit got we %b a %0d d %h exp 1 5 3f800000", rf_we4, rf_waddr4, rf_wdata4); end
        checks++; if (rd_data4 !== 32'd0) begin errors++; $display("FAIL single_old got %h exp 0", rd_data4); end
        checks++; if (hazard4 !== 1'b0) begin errors++; $display("FAIL single_hz_commit got %b exp 0", hazard4); end
        tick();  // E3
        checks++; if (rd_data4 !== 32'h3F800000 || rf_we4 !== 1'b0 || busy4 !== 1'b0) begin errors++; $display("FAIL single_after got rd %h we %b busy %b exp 3f800000 0 0", rd_data4, rf_we4, busy4); end
    endtask

    task automatic test_stall();
        rd_addr4 = 5'd5; enable = 1'b1;
        instruction = fmv(5'd5); data_fromXReg = 32'h40000000;
        tick();  // E0
        instruction = 32'd0;
        tick();  // E1
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (busy4 !== 1'b1 || hazard4 !== 1'b1 || rf_we4 !== 1'b0) begin errors++; $display("FAIL stall_%0d got busy %b hz %b we %b exp 1 1 0", i, busy4, hazard4, rf_we4); end
            tick();
        end
        enable = 1'b1; #1;
        checks++; if (rf_we4 !== 1'b0 || busy4 !== 1'b1) begin errors++; $display("FAIL stall_resume got we %b busy %b exp 0 1", rf_we4, busy4); end
        tick();  // E2
        enable = 1'b0; #1;
        checks++; if (rf_we4 !== 1'b0 || hazard4 !== 1'b1) begin errors++; $display("FAIL stall_commit_hold got we %b hz %b exp 0 1", rf_we4, hazard4); end
        tick();
        enable = 1'b1; #1;
        checks++; if (rf_we4 !== 1'b1 || rf_wdata4 !== 32'h40000000) begin errors++; $display("FAIL stall_commit got we %b d %h exp 1 40000000", rf_we4, rf_wdata4); end
        checks++; if (rd_data4 !== 32'h3F800000) begin errors++; $display("FAIL stall_old got %h exp 3f800000", rd_data4); end
        tick();  // E3
        checks++; if (rd_data4 !== 32'h40000000) begin errors++; $display("FAIL stall_after got %h exp 40000000", rd_data4); end
    endtask

    task automatic test_back_to_back();
        rd_addr4 = 5'd7; enable = 1'b1;
        instruction = fmv(5'd7); data_fromXReg = 32'h11111111;
        tick();  // E0
        data_fromXReg = 32'h22222222;
        tick();  // E1
        instruction = 32'd0; #1;
        checks++; if (rf_we4 !== 1'b0 || hazard4 !== 1'b1) begin errors++; $display("FAIL order_e1 got we %b hz %b exp 0 1", rf_we4, hazard4); end
        tick();  // E2
        checks++; if (rf_we4 !== 1'b1 || rf_wdata4 !== 32'h11111111 || hazard4 !== 1'b1) begin errors++; $display("FAIL order_first got we %b d %h hz %b exp 1 11111111 1", rf_we4, rf_wdata4, hazard4); end
        tick();  // E3
        checks++; if (rf_we4 !== 1'b1 || rf_wdata4 !== 32'h22222222 || rd_data4 !== 32'h11111111) begin errors++; $display("FAIL order_second got we %b d %h rd %h exp 1 22222222 11111111", rf_we4, rf_wdata4, rd_data4); end
        tick();  // E4
        checks++; if (rd_data4 !== 32'h22222222 || busy4 !== 1'b0) begin errors++; $display("FAIL order_final got rd %h busy %b exp 22222222 0", rd_data4, busy4); end
    endtask

    task automatic test_decode_filter();
        enable = 1'b1; data_fromXReg = 32'hAAAAAAAA;
        instruction = {7'b1110000, 5'd0, 5'd1, 3'b000, 5'd5, 7'b1010011};  // FMV.X.W
        #1;
        checks++; if (rf_we1 !== 1'b0) begin errors++; $display("FAIL filter_fmvxw_we1 got %b exp 0", rf_we1); end
        tick();
        instruction = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd7, 7'b1010011};  // FADD.S
        #1;
        checks++; if (rf_we1 !== 1'b0 || busy4 !== 1'b0) begin errors++; $display("FAIL filter_fadd got we1 %b busy %b exp 0 0", rf_we1, busy4); end
        tick();
        instruction = 32'd0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (rf_we4 !== 1'b0 || busy4 !== 1'b0) begin errors++; $display("FAIL filter_idle_%0d got we %b busy %b exp 0 0", i, rf_we4, busy4); end
            tick();
        end
        rd_addr4 = 5'd5; #1;
        checks++; if (rd_data4 !== 32'h40000000) begin errors++; $display("FAIL filter_f5 got %h exp 40000000", rd_data4); end
        rd_addr4 = 5'd7; #1;
        checks++; if (rd_data4 !== 32'h22222222) begin errors++; $display("FAIL filter_f7 got %h exp 22222222", rd_data4); end
    endtask

    task automatic test_reset_midflight();
        rd_addr4 = 5'd3; enable = 1'b1;
        instruction = fmv(5'd3); data_fromXReg = 32'hDEADBEEF;
        tick();  // E0
        instruction = 32'd0;
        tick();  // E1
        rst = 1'b0; #1;
        checks++; if (busy4 !== 1'b0 || rf_we4 !== 1'b0 || rd_data4 !== 32'd0) begin errors++; $display("FAIL rstmid_async got busy %b we %b rd %h exp 0 0 0", busy4, rf_we4, rd_data4); end
        rd_addr4 = 5'd7; #1;
        checks++; if (rd_data4 !== 32'd0) begin errors++; $display("FAIL rstmid_clear got %h exp 0", rd_data4); end
        tick(); tick();
        rst = 1'b1; rd_addr4 = 5'd3;
        instruction = fmv(5'd3); data_fromXReg = 32'h12345678;
        tick();  // first enabled edge after reset
        instruction = 32'd0; #1;
        checks++; if (busy4 !== 1'b1) begin errors++; $display("FAIL rstmid_accept got busy %b exp 1", busy4); end
        tick(); tick();
        checks++; if (rf_we4 !== 1'b1 || rf_waddr4 !== 5'd3 || rf_wdata4 !== 32'h12345678) begin errors++; $display("FAIL rstmid_commit got we %b a %0d d %h exp 1 3 12345678", rf_we4, rf_waddr4, rf_wdata4); end
        tick();
        checks++; if (rd_data4 !== 32'h12345678) begin errors++; $display("FAIL rstmid_after got %h exp 12345678", rd_data4); end
    endtask

    task automatic test_round_trip();
        enable = 1'b1; rd_addr1 = 5'd1;
        instruction = fmv(5'd9); data_fromXReg = 32'h55555555;
        #1;
        checks++; if (rf_we1 !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL rt_oob got we %b busy %b exp 0 0", rf_we1, busy1); end
        tick();
        rd_addr1 = 5'd0; instruction = fmv(5'd0); data_fromXReg = 32'hC0490FDB;
        #1;
        checks++; if (rf_we1 !== 1'b1 || rf_waddr1 !== 5'd0 || rf_wdata1 !== 32'hC0490FDB) begin errors++; $display("FAIL rt_commit got we %b a %0d d %h exp 1 0 c0490fdb", rf_we1, rf_waddr1, rf_wdata1); end
        checks++; if (rd_data1 !== 32'd0 || hazard1 !== 1'b0) begin errors++; $display("FAIL rt_old got rd %h hz %b exp 0 0", rd_data1, hazard1); end
        tick();  // E0
        instruction = 32'd0; #1;
        checks++; if (rd_data1 !== 32'hC0490FDB || rf_we1 !== 1'b0) begin errors++; $display("FAIL rt_after got rd %h we %b exp c0490fdb 0", rd_data1, rf_we1); end
        rd_addr1 = 5'd1; #1;
        checks++; if (rd_data1 !== 32'd0) begin errors++; $display("FAIL rt_alias got %h exp 0", rd_data1); end
    endtask

    initial begin
        rst = 1'b0; enable = 1'b0; instruction = 32'd0; data_fromXReg = 32'd0;
        rd_addr4 = 5'd0; rd_addr1 = 5'd0;
        test_reset();
        test_single();
        test_stall();
        test_back_to_back();
        test_decode_filter();
        test_reset_midflight();
        test_round_trip();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
